// File: rtl/lut_sweep_reader_if.sv
// Output word stream of the LUT sweep reader: packed truth-table words with valid/ready/last.
interface lut_sweep_reader_if #(
  parameter int unsigned WORD_W = 16
) ();
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/lut_sweep_reader.sv
// Sweeps every input code of a LUT neuron, packs the returned bits LSB-first
// into words and streams them out; the ROM contents read back as a bitstream.
module lut_sweep_reader #(
  parameter int unsigned IN_W    = 6,
  parameter int unsigned OUT_W   = 1,
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned LUT_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IN_W-1:0]      lut_addr,
  input  logic [OUT_W-1:0]     lut_data,
  lut_sweep_reader_if.master   out_if,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NUM_CODES = 2 ** IN_W;
  localparam int unsigned SLOTS     = WORD_W / OUT_W;
  localparam int unsigned LAST_SLOT = SLOTS - 1;
  localparam int unsigned SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNT_W     = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;

  if ((WORD_W % OUT_W) != 0) begin : g_chk_slots
    $error("lut_sweep_reader: WORD_W must be a multiple of OUT_W");
  end
  if (((NUM_CODES * OUT_W) % WORD_W) != 0) begin : g_chk_words
    $error("lut_sweep_reader: table size must be a multiple of WORD_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     addr_q,  addr_d;
  logic [SLOT_W-1:0]   slot_q,  slot_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [WORD_W-1:0]   data_q,  data_d;
  logic                valid_q, valid_d;
  logic                last_q,  last_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                capture;

  // State and output registers; every output is a flop so out_ready never reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      slot_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      slot_q  <= slot_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    capture = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          addr_d  = '0;
          slot_d  = '0;
          data_d  = '0;
        end
      end
      S_ISSUE: begin
        if (LUT_LAT == 0) begin
          capture = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(LUT_LAT - 1)) begin
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_EMIT: begin
        if (out_if.out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            data_d  = '0;
            slot_d  = '0;
            addr_d  = addr_q + IN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Drop the neuron's bits into the current slot and advance or emit.
    if (capture) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        if (slot_q == SLOT_W'(i)) begin
          data_d[i*OUT_W +: OUT_W] = lut_data;
        end
      end
      if (slot_q == SLOT_W'(LAST_SLOT)) begin
        state_d = S_EMIT;
      end else begin
        state_d = S_ISSUE;
        slot_d  = slot_q + SLOT_W'(1);
        addr_d  = addr_q + IN_W'(1);
      end
    end

    valid_d = (state_d == S_EMIT);
    last_d  = (state_d == S_EMIT) && (addr_d == {IN_W{1'b1}});
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  assign lut_addr         = addr_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_lut_sweep_reader.sv
// Bench for lut_sweep_reader: a combinational-neuron instance and a 2-cycle-latency
// instance, with scoreboard queues checked by per-instance output monitors.
module tb_lut_sweep_reader;

  localparam int unsigned IN_W   = 6;
  localparam int unsigned OUT_W  = 1;
  localparam int unsigned WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] d;
    logic              l;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   words0 = 0;
  int   words1 = 0;

  // Combinational neuron under test 0
  logic              start0 = 1'b0;
  logic [IN_W-1:0]   addr0;
  logic [OUT_W-1:0]  data0;
  logic              busy0, done0;
  int                mode0 = 0;
  lut_sweep_reader_if #(.WORD_W(WORD_W)) if0 ();

  always_comb data0 = (mode0 == 0) ? OUT_W'(addr0[0]) : OUT_W'(addr0 == IN_W'(37));

  lut_sweep_reader #(.IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W), .LUT_LAT(0)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .lut_addr (addr0),
    .lut_data (data0),
    .out_if   (if0),
    .busy     (busy0),
    .done     (done0)
  );

  // Two-cycle registered neuron under test 1
  logic              start1 = 1'b0;
  logic [IN_W-1:0]   addr1;
  logic [OUT_W-1:0]  data1;
  logic              busy1, done1;
  logic              pipe_a = 1'b0;
  logic              pipe_b = 1'b0;
  lut_sweep_reader_if #(.WORD_W(WORD_W)) if1 ();

  always @(posedge clk) begin
    pipe_a <= addr1[5];
    pipe_b <= pipe_a;
  end
  assign data1 = OUT_W'(pipe_b);

  lut_sweep_reader #(.IN_W(IN_W), .OUT_W(OUT_W), .WORD_W(WORD_W), .LUT_LAT(2)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .lut_addr (addr1),
    .lut_data (data1),
    .out_if   (if1),
    .busy     (busy1),
    .done     (done1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitors: pop the scoreboard on every accepted word
  always @(negedge clk) begin
    exp_t e;
    if (if0.out_valid && if0.out_ready) begin
      words0++;
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut0_extra_word: got %0h want none", if0.out_data);
      end else begin
        e = q0.pop_front();
        chk("dut0_word", 32'(if0.out_data), 32'(e.d));
        chk("dut0_last", 32'(if0.out_last), 32'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.out_valid && if1.out_ready) begin
      words1++;
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dut1_extra_word: got %0h want none", if1.out_data);
      end else begin
        e = q1.pop_front();
        chk("dut1_word", 32'(if1.out_data), 32'(e.d));
        chk("dut1_last", 32'(if1.out_last), 32'(e.l));
      end
    end
  end

  task automatic push_words(input bit which, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3);
    if (which == 1'b0) begin
      q0.push_back('{d: w0, l: 1'b0});
      q0.push_back('{d: w1, l: 1'b0});
      q0.push_back('{d: w2, l: 1'b0});
      q0.push_back('{d: w3, l: 1'b1});
    end else begin
      q1.push_back('{d: w0, l: 1'b0});
      q1.push_back('{d: w1, l: 1'b0});
      q1.push_back('{d: w2, l: 1'b0});
      q1.push_back('{d: w3, l: 1'b1});
    end
  endtask

  // One sweep on dut0; optional 10-cycle stall on word 1 and stray start pulses
  task automatic sweep0(input int md, input int exp_done, input bit stall, input bit restart,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3);
    int issue_n = 0;
    int dones   = 0;
    int stall_n = 0;
    int base;
    mode0 = md;
    push_words(1'b0, w0, w1, w2, w3);
    base = words0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int k = 1; k <= exp_done + 4; k++) begin
      start0 = restart && (k == 5 || k == 17);
      if (stall && if0.out_valid && (words0 - base) == 1 && stall_n < 10) begin
        if0.out_ready = 1'b0;
        stall_n++;
      end else begin
        if0.out_ready = 1'b1;
      end
      @(negedge clk);
      if (!if0.out_ready) begin
        chk("stall_valid", 32'(if0.out_valid), 32'd1);
        chk("stall_data", 32'(if0.out_data), 32'(w1));
        chk("stall_last", 32'(if0.out_last), 32'd0);
        chk("stall_addr", 32'(addr0), 32'd31);
      end
      if (!if0.out_valid && busy0 && !done0) begin
        chk("addr_seq", 32'(addr0), 32'(issue_n));
        issue_n++;
      end
      chk("busy", 32'(busy0), 32'(k <= exp_done));
      if (done0) begin
        dones++;
        chk("done_cycle", 32'(k), 32'(exp_done));
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0;
    if0.out_ready = 1'b1;
    chk("issue_count", 32'(issue_n), 32'd64);
    chk("done_count", 32'(dones), 32'd1);
    chk("word_count", 32'(words0 - base), 32'd4);
    chk("queue_empty", 32'(q0.size()), 32'd0);
    chk("idle_addr", 32'(addr0), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int dones;
    int nonemit;
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_data", 32'(if0.out_data), 32'd0);
    chk("rst_valid", 32'(if0.out_valid), 32'd0);
    chk("rst_last", 32'(if0.out_last), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst1_busy", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    sweep0(0, 69, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    sweep0(1, 69, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000);

    // Latency-2 neuron: each code held three cycles
    push_words(1'b1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF);
    base = words1;
    dones = 0;
    nonemit = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 201; k++) begin
      @(negedge clk);
      if (!if1.out_valid && busy1 && !done1) begin
        chk("lat2_addr", 32'(addr1), 32'(nonemit / 3));
        nonemit++;
      end
      if (done1) begin
        dones++;
        chk("lat2_done_cycle", 32'(k), 32'd197);
      end
      @(posedge clk); #1;
    end
    chk("lat2_read_cycles", 32'(nonemit), 32'd192);
    chk("lat2_done_count", 32'(dones), 32'd1);
    chk("lat2_word_count", 32'(words1 - base), 32'd4);
    chk("lat2_queue_empty", 32'(q1.size()), 32'd0);

    sweep0(0, 79, 1'b1, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);
    sweep0(0, 69, 1'b0, 1'b1, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);

    // Asynchronous reset mid-sweep: only word 0 escapes before code 20
    mode0 = 0;
    q0.push_back('{d: 16'hAAAA, l: 1'b0});
    base = words0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (addr0 !== IN_W'(20) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_addr20", 32'(addr0), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(addr0), 32'd0);
    chk("arst_data", 32'(if0.out_data), 32'd0);
    chk("arst_valid", 32'(if0.out_valid), 32'd0);
    chk("arst_last", 32'(if0.out_last), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_hold_valid", 32'(if0.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("post_rst_idle_valid", 32'(if0.out_valid), 32'd0);
    end
    chk("arst_word_count", 32'(words0 - base), 32'd1);
    chk("arst_queue_empty", 32'(q0.size()), 32'd0);
    @(posedge clk); #1;
    sweep0(0, 69, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
